// File: rtl/bpi_intrf_seq.sv
`default_nettype none
// ============================================================================
// Module      : bpi_intrf_seq
// Description : Parametrised BPI parallel-flash strobe sequencer. Generates
//               E/G/W/L flash strobes for single-word writes and multi-word
//               reads, plus capture/load/address-increment strobes for the
//               datapath. All outputs are registered and decoded from the
//               next state, so while state==S the outputs equal decode(S).
// Ports       : CLK, RST (async, active-high)
//               EXECUTE, READ, WRITE, NWORDS[NW_W-1:0]  - command inputs
//               BUSY, CAP, E, G, W, L, LOAD, ADDR_INC,
//               DONE, ERR                               - registered strobes
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module bpi_intrf_seq #(
  parameter int RD_WAIT = 3,
  parameter int PG_WAIT = 1,
  parameter int WE_CYC  = 2,
  parameter int WR_RCV  = 0,
  parameter int NW_W    = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EXECUTE,
  input  logic            READ,
  input  logic            WRITE,
  input  logic [NW_W-1:0] NWORDS,
  output logic            BUSY,
  output logic            CAP,
  output logic            E,
  output logic            G,
  output logic            W,
  output logic            L,
  output logic            LOAD,
  output logic            ADDR_INC,
  output logic            DONE,
  output logic            ERR
);

  localparam int MAX_A = (RD_WAIT > PG_WAIT) ? RD_WAIT : PG_WAIT;
  localparam int MAX_B = (WE_CYC > WR_RCV) ? WE_CYC : WR_RCV;
  localparam int MAXW  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAXW + 1);

  // Held states load N-1 and leave when the counter reaches zero.
  localparam logic [CW-1:0] RD_LD = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] PG_LD = CW'(PG_WAIT - 1);
  localparam logic [CW-1:0] WE_LD = CW'(WE_CYC - 1);
  localparam int            WR_I  = (WR_RCV > 0) ? (WR_RCV - 1) : 0;
  localparam logic [CW-1:0] WR_LD = CW'(WR_I);

  localparam logic [3:0] S_STANDBY = 4'd0;
  localparam logic [3:0] S_CAPTURE = 4'd1;
  localparam logic [3:0] S_LATCH   = 4'd2;
  localparam logic [3:0] S_WE      = 4'd3;
  localparam logic [3:0] S_WR_RCV  = 4'd4;
  localparam logic [3:0] S_RD_WAIT = 4'd5;
  localparam logic [3:0] S_RD_LOAD = 4'd6;
  localparam logic [3:0] S_RD_NEXT = 4'd7;
  localparam logic [3:0] S_RD_HOLD = 4'd8;

  logic [3:0]      state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [NW_W-1:0] rem, rem_nxt;
  logic            err_nxt;

  always_comb begin
    state_nxt = S_STANDBY;
    cnt_nxt   = cnt;
    rem_nxt   = rem;
    err_nxt   = 1'b0;
    case (state)
      S_STANDBY: state_nxt = EXECUTE ? S_CAPTURE : S_STANDBY;
      S_CAPTURE: begin
        state_nxt = S_LATCH;
        rem_nxt   = (NWORDS == '0) ? NW_W'(1) : NWORDS;
      end
      S_LATCH: begin
        if (WRITE) begin
          state_nxt = S_WE;
          cnt_nxt   = WE_LD;
        end else if (READ) begin
          state_nxt = S_RD_WAIT;
          cnt_nxt   = RD_LD;
        end else begin
          state_nxt = S_STANDBY;
          err_nxt   = 1'b1;
        end
      end
      S_WE: begin
        if (cnt != '0) begin
          state_nxt = S_WE;
          cnt_nxt   = cnt - 1'b1;
        end else if (WR_RCV > 0) begin
          state_nxt = S_WR_RCV;
          cnt_nxt   = WR_LD;
        end else begin
          state_nxt = S_STANDBY;
        end
      end
      S_WR_RCV: begin
        if (cnt != '0) begin
          state_nxt = S_WR_RCV;
          cnt_nxt   = cnt - 1'b1;
        end else begin
          state_nxt = S_STANDBY;
        end
      end
      S_RD_WAIT: begin
        if (cnt != '0) begin
          state_nxt = S_RD_WAIT;
          cnt_nxt   = cnt - 1'b1;
        end else begin
          state_nxt = S_RD_LOAD;
        end
      end
      S_RD_LOAD: begin
        rem_nxt   = rem - 1'b1;
        state_nxt = (rem > NW_W'(1)) ? S_RD_NEXT : S_RD_HOLD;
      end
      S_RD_NEXT: begin
        state_nxt = S_RD_WAIT;
        cnt_nxt   = PG_LD;
      end
      S_RD_HOLD: state_nxt = S_STANDBY;
      default:   state_nxt = S_STANDBY;
    endcase
  end

  // Decode of the next state; DONE in a held state depends on whether the
  // next cycle is its last one (counter reaching zero).
  logic busy_n, cap_n, e_n, g_n, w_n, l_n, load_n, inc_n, done_n;

  always_comb begin
    busy_n = (state_nxt != S_STANDBY);
    cap_n  = (state_nxt == S_CAPTURE);
    l_n    = (state_nxt == S_LATCH);
    w_n    = (state_nxt == S_WE);
    g_n    = (state_nxt == S_RD_WAIT) || (state_nxt == S_RD_LOAD) ||
             (state_nxt == S_RD_NEXT) || (state_nxt == S_RD_HOLD);
    e_n    = l_n || w_n || g_n || (state_nxt == S_WR_RCV);
    load_n = (state_nxt == S_RD_LOAD);
    inc_n  = (state_nxt == S_RD_NEXT);
    done_n = (state_nxt == S_RD_HOLD) ||
             ((state_nxt == S_WR_RCV) && (cnt_nxt == '0)) ||
             ((state_nxt == S_WE) && (cnt_nxt == '0) && (WR_RCV == 0));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_STANDBY;
      cnt      <= '0;
      rem      <= '0;
      BUSY     <= 1'b0;
      CAP      <= 1'b0;
      E        <= 1'b0;
      G        <= 1'b0;
      W        <= 1'b0;
      L        <= 1'b0;
      LOAD     <= 1'b0;
      ADDR_INC <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rem      <= rem_nxt;
      BUSY     <= busy_n;
      CAP      <= cap_n;
      E        <= e_n;
      G        <= g_n;
      W        <= w_n;
      L        <= l_n;
      LOAD     <= load_n;
      ADDR_INC <= inc_n;
      DONE     <= done_n;
      ERR      <= err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bpi_intrf_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bpi_intrf_seq
// Description : Scoreboard bench for bpi_intrf_seq. Three instances:
//               0 = defaults, 1 = PG_WAIT=2 (burst), 2 = WR_RCV=2.
//               Output vector {BUSY,CAP,E,G,W,L,LOAD,ADDR_INC,DONE,ERR} is
//               compared against a per-instance queue of expected vectors
//               whenever it is non-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bpi_intrf_seq;

  localparam logic [9:0] V_CAP  = 10'b1100000000;
  localparam logic [9:0] V_LAT  = 10'b1010010000;
  localparam logic [9:0] V_WE   = 10'b1010100000;
  localparam logic [9:0] V_WED  = 10'b1010100010;
  localparam logic [9:0] V_RCV  = 10'b1010000000;
  localparam logic [9:0] V_RCVD = 10'b1010000010;
  localparam logic [9:0] V_RDW  = 10'b1011000000;
  localparam logic [9:0] V_RDL  = 10'b1011001000;
  localparam logic [9:0] V_RDN  = 10'b1011000100;
  localparam logic [9:0] V_RDH  = 10'b1011000010;
  localparam logic [9:0] V_ERR  = 10'b0000000001;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       exe [3];
  logic       rd  [3];
  logic       wr  [3];
  logic [7:0] nw  [3];
  wire  [9:0] ov  [3];

  logic [9:0] q [3][$];
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    wire [9:0] o;
    bpi_intrf_seq #(
      .RD_WAIT(3),
      .PG_WAIT((i == 1) ? 2 : 1),
      .WE_CYC (2),
      .WR_RCV ((i == 2) ? 2 : 0),
      .NW_W   (8)
    ) u_dut (
      .CLK     (CLK),
      .RST     (RST),
      .EXECUTE (exe[i]),
      .READ    (rd[i]),
      .WRITE   (wr[i]),
      .NWORDS  (nw[i]),
      .BUSY    (o[9]),
      .CAP     (o[8]),
      .E       (o[7]),
      .G       (o[6]),
      .W       (o[5]),
      .L       (o[4]),
      .LOAD    (o[3]),
      .ADDR_INC(o[2]),
      .DONE    (o[1]),
      .ERR     (o[0])
    );
    assign ov[i] = o;
  end

  // Monitor: every non-idle output cycle is matched against the queue.
  always @(negedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < 3; i++) begin
        if (ov[i] != 10'd0) begin
          checks++;
          if (q[i].size() == 0) begin
            errors++;
            $display("FAIL dut%0d unexpected output got %b expected idle", i, ov[i]);
          end else begin
            logic [9:0] exp_v;
            exp_v = q[i].pop_front();
            if (ov[i] !== exp_v) begin
              errors++;
              $display("FAIL dut%0d trace got %b expected %b at %0t", i, ov[i], exp_v, $time);
            end
          end
        end
      end
    end
  end

  task automatic push(input int i, input logic [9:0] v, input int n);
    for (int k = 0; k < n; k++) q[i].push_back(v);
  endtask

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, got, exp_v);
    end
  endtask

  // One-cycle EXECUTE pulse, command held for the transaction, then cleared.
  task automatic run(input int i, input logic r, input logic w, input logic [7:0] n,
                     input int cycles);
    @(negedge CLK);
    exe[i] = 1'b1; rd[i] = r; wr[i] = w; nw[i] = n;
    @(negedge CLK);
    exe[i] = 1'b0;
    repeat (cycles) @(negedge CLK);
    rd[i] = 1'b0; wr[i] = 1'b0; nw[i] = 8'd0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      exe[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0; nw[i] = 8'd0;
    end
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 3; i++) check($sformatf("reset_dut%0d", i), ov[i], 10'd0);
    RST = 1'b0;

    // Reset mid-read: asynchronous clear during RD_WAIT.
    push(0, V_CAP, 1); push(0, V_LAT, 1); push(0, V_RDW, 2);
    @(negedge CLK);
    exe[0] = 1'b1; rd[0] = 1'b1; nw[0] = 8'd1;
    @(negedge CLK);
    exe[0] = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    #1 check("async_reset_mid_read", ov[0], 10'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0; rd[0] = 1'b0;

    // Default single read after reset.
    push(0, V_CAP, 1); push(0, V_LAT, 1); push(0, V_RDW, 3);
    push(0, V_RDL, 1); push(0, V_RDH, 1);
    run(0, 1'b1, 1'b0, 8'd1, 9);

    // Default write.
    push(0, V_CAP, 1); push(0, V_LAT, 1); push(0, V_WE, 1); push(0, V_WED, 1);
    run(0, 1'b0, 1'b1, 8'd1, 6);

    // READ and WRITE both high: write only.
    push(0, V_CAP, 1); push(0, V_LAT, 1); push(0, V_WE, 1); push(0, V_WED, 1);
    run(0, 1'b1, 1'b1, 8'd1, 6);

    // Neither READ nor WRITE: ERR pulse in the STANDBY cycle.
    push(0, V_CAP, 1); push(0, V_LAT, 1); push(0, V_ERR, 1);
    run(0, 1'b0, 1'b0, 8'd1, 5);

    // Two-word read with default page wait.
    push(0, V_CAP, 1); push(0, V_LAT, 1); push(0, V_RDW, 3); push(0, V_RDL, 1);
    push(0, V_RDN, 1); push(0, V_RDW, 1); push(0, V_RDL, 1); push(0, V_RDH, 1);
    run(0, 1'b1, 1'b0, 8'd2, 10);

    // Burst of three with PG_WAIT=2.
    push(1, V_CAP, 1); push(1, V_LAT, 1); push(1, V_RDW, 3); push(1, V_RDL, 1);
    for (int k = 0; k < 2; k++) begin
      push(1, V_RDN, 1); push(1, V_RDW, 2); push(1, V_RDL, 1);
    end
    push(1, V_RDH, 1);
    run(1, 1'b1, 1'b0, 8'd3, 18);

    // NWORDS=0 behaves as one word.
    push(1, V_CAP, 1); push(1, V_LAT, 1); push(1, V_RDW, 3);
    push(1, V_RDL, 1); push(1, V_RDH, 1);
    run(1, 1'b1, 1'b0, 8'd0, 9);

    // Full-scale count: 255 words, no wrap.
    push(0, V_CAP, 1); push(0, V_LAT, 1); push(0, V_RDW, 3); push(0, V_RDL, 1);
    for (int k = 0; k < 254; k++) begin
      push(0, V_RDN, 1); push(0, V_RDW, 1); push(0, V_RDL, 1);
    end
    push(0, V_RDH, 1);
    run(0, 1'b1, 1'b0, 8'd255, 775);

    // WR_RCV=2 write with EXECUTE held: back-to-back transactions.
    for (int k = 0; k < 2; k++) begin
      push(2, V_CAP, 1); push(2, V_LAT, 1); push(2, V_WE, 2);
      push(2, V_RCV, 1); push(2, V_RCVD, 1);
    end
    @(negedge CLK);
    exe[2] = 1'b1; wr[2] = 1'b1; nw[2] = 8'd1;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge CLK);
        if (ov[2][1]) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL b2b_done_timeout got no DONE expected DONE within 20 cycles");
      end
    end
    @(negedge CLK);
    check("b2b_standby_gap", {9'd0, ov[2][9]}, 10'd0);
    @(negedge CLK);
    check("b2b_recapture", {9'd0, ov[2][8]}, 10'd1);
    exe[2] = 1'b0;
    repeat (8) @(negedge CLK);
    wr[2] = 1'b0; nw[2] = 8'd0;

    repeat (4) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (q[i].size() != 0) begin
        errors++;
        $display("FAIL dut%0d missing outputs got %0d left expected 0", i, q[i].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
